// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge.
// No logic; the counter width helper sizes dmem_timeout_cnt from TIMEOUT.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2,
    WR_WAIT = 2'd3
  } dmem_state_t;

  localparam logic [31:0] DMEM_RD_ERR_DATA = 32'h0;

  function automatic int dmem_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Wait-cycle counter for one bus transaction; o_expired flags the TIMEOUT-th wait cycle.
// Registered count, combinational expiry; clear dominates enable.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = dmem_cnt_width(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Count holds completed no-ack cycles, so TIMEOUT-1 marks the last allowed one.
  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Core data port to req/ack bus bridge: loads stall >=2 cycles, stores posted via one-entry buffer.
// Any access while the buffer is busy stalls the core; hung transactions abandoned after TIMEOUT.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memen,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  dmem_state_t r_state;
  logic [31:0] r_rdata;
  logic        r_bus_req;
  logic [3:0]  r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_err;

  logic w_waiting;
  logic w_expired;
  logic w_stall;

  assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT);

  dmem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (!w_waiting),
    .i_en      (w_waiting && !bus_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (memen) begin
            r_bus_addr <= addr & 32'hFFFF_FFFC;
            r_bus_req  <= 1'b1;
            if (wea != 4'b0000) begin
              r_bus_we    <= wea;
              r_bus_wdata <= wdata;
              r_state     <= WR_WAIT;
            end else begin
              r_bus_we <= 4'b0000;
              r_state  <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Ack wins over a simultaneous expiry.
          if (bus_ack) begin
            r_rdata   <= bus_rdata;
            r_bus_req <= 1'b0;
            r_state   <= RD_DONE;
          end else if (w_expired) begin
            r_rdata   <= DMEM_RD_ERR_DATA;
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= RD_DONE;
          end
        end
        RD_DONE: begin
          r_state <= IDLE;
        end
        WR_WAIT: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_state   <= IDLE;
          end else if (w_expired) begin
            r_bus_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Gated by reset so the core is released immediately on asynchronous assertion.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      IDLE:    w_stall = memen && (wea == 4'b0000);
      RD_WAIT: w_stall = 1'b1;
      RD_DONE: w_stall = 1'b0;
      WR_WAIT: w_stall = memen;
      default: w_stall = 1'b0;
    endcase
  end

  assign stall     = reset && w_stall;
  assign rdata     = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_err   = r_bus_err;

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge directly downstream of the pipelined MIPS core's memory stage. Converts the core's single-cycle data port (`memen`, `wea`, `aluout`, `writedata`, `readdata`) into a req/ack bus with variable wait states. Stores are posted through a one-entry write buffer; loads stall the core until data returns. A per-transaction timeout guards against a hung bus.

## Interface
- `TIMEOUT`, default 255: maximum cycles `bus_req` may stay high without `bus_ack` before the transaction is abandoned; legal range 1..65535.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memen` in 1: core data access valid this cycle.
- `wea` in 4: byte write enables; nonzero = store, zero with `memen` = load.
- `addr` in 32: byte address from the core's memory stage (`aluout`).
- `wdata` in 32: store data, already byte-lane aligned by the core.
- `rdata` out 32: registered load data to the core's `readdata`.
- `stall` out 1: freezes the core pipeline; combinational.
- `bus_req` out 1: bus request, registered.
- `bus_we` out 4: byte enables for the bus transaction; zero = read.
- `bus_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: store data.
- `bus_ack` in 1: transaction complete when sampled high with `bus_req` high.
- `bus_rdata` in 32: read data, valid in the `bus_ack` cycle.
- `bus_err` out 1: sticky timeout flag, cleared only by reset.

## Operation
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT.
- IDLE + load: latch address, `bus_we`=0, `bus_req`=1 next cycle, go RD_WAIT; `stall`=1 in the issuing cycle.
- RD_WAIT: `stall`=1; on `bus_ack`, register `bus_rdata` into `rdata`, drop `bus_req`, go RD_DONE.
- RD_DONE: `stall`=0 for exactly one cycle; the core consumes `rdata`. Return to IDLE. A new access presented in RD_DONE is ignored; the core re-presents it after advancing.
- IDLE + store: latch address/`wea`/`wdata` into the write buffer, `bus_req`=1 next cycle, go WR_WAIT; `stall`=0 (posted).
- WR_WAIT: on `bus_ack`, drop `bus_req`, go IDLE. Any `memen` access during WR_WAIT drives `stall`=1 until the cycle after ack, when it is accepted from IDLE. Loads never bypass the write buffer.
- No access (`memen`=0): `stall`=0, no state change.
- Timeout: counter clears on entry to a wait state and increments each wait cycle without ack. On reaching `TIMEOUT`, drop `bus_req` and set `bus_err`. A read delivers `rdata`=0 via RD_DONE; a write is discarded and the FSM returns to IDLE. Ack in the same cycle as expiry counts as success.
- `bus_addr`/`bus_we`/`bus_wdata` are held stable while `bus_req`=1.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `rdata`, `bus_addr`, `bus_wdata`=0; `bus_we`=0; `bus_req`=0; `bus_err`=0; counter=0. `stall`=0 (IDLE, `memen` low).
- Reset mid-transaction: `bus_req` drops immediately and any posted write is lost.
- Load presented in cycle N, ack in the first request cycle (N+1): `stall` high in N and N+1, low in N+2 with `rdata` valid. Minimum load penalty is 2 cycles; each extra wait cycle adds one.
- Store in cycle N: no stall; `bus_req` high from N+1 until ack inclusive.
- Back-to-back stores at N and N+1, first acked at N+k: second store stalled N+1..N+k, accepted at N+k+1.
- Earliest timeout: `bus_req` high for `TIMEOUT` cycles, dropped on the next edge.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE, RD_WAIT, RD_DONE, WR_WAIT), constant `DMEM_RD_ERR_DATA = 32'h0`, counter width derived as `$clog2(TIMEOUT+1)`.
- One sub-module, `dmem_timeout_cnt`: clear/enable/expired counter parameterised by `TIMEOUT`. The FSM and write buffer stay in `dmem_bridge`.

## Test plan
- Load at 0x1004, `bus_ack` in the first request cycle with `bus_rdata`=0xCAFEF00D -> `stall` high 2 cycles, `bus_addr`=0x1004, `rdata`=0xCAFEF00D in the release cycle.
- Store `wea`=4'b0011, `wdata`=0x0000BEEF to 0x2002 -> no stall; `bus_addr`=0x2000, `bus_we`=0011, held through 3 wait cycles until ack.
- Store then immediate load to the same word, write ack after 4 cycles -> load stalled until the cycle after the write ack, then the read is issued; no bypass.
- `TIMEOUT`=4, load with `bus_ack` never asserted -> `bus_req` high 4 cycles then low, `bus_err`=1 sticky, `rdata`=0, core released.
- Assert `reset` while in RD_WAIT -> `bus_req`, `stall`, `bus_err` all 0 asynchronously; after release, a fresh load completes normally.
